// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

    localparam int unsigned ENTRY_W = $bits(ps2_entry_t);

endpackage

// File: rtl/ps2_key_fifo.sv
// Show-ahead synchronous FIFO for key events; head reads as zero while empty.
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = ENTRY_W,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             FPGAClk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot, so a push while full is accepted in the same cycle.
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CNT_W'(1);
        end
    end

    always_ff @(posedge FPGAClk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge FPGAClk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: oversampled clock filter, frame FSM, prefix/shift decode, event FIFO.
// Define PS2_PARITY_CHECK_EN to drop bad-parity bytes with an err_parity pulse.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                            FPGAClk,
    input  logic                            rst,
    input  logic                            PS2Clk,
    input  logic                            datain,
    output logic                            key_valid,
    input  logic                            key_ready,
    output logic [7:0]                      key_code,
    output logic                            key_break,
    output logic                            key_ext,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            shift,
    output logic                            err_parity,
    output logic                            err_frame,
    output logic                            err_overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] filt;
    logic [FILTER_LEN-1:0] filt_next;
    logic                  filt_clk;
    logic                  fall;
    logic                  data_s;

    assign filt_next = {filt[FILTER_LEN-2:0], clk_sync[1]};
    assign data_s    = dat_sync[1];

    // Filtered clock only moves when the whole window agrees; falling moves strobe fall.
    always_ff @(posedge FPGAClk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            filt     <= '1;
            filt_clk <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], PS2Clk};
            dat_sync <= {dat_sync[0], datain};
            filt     <= filt_next;
            fall     <= 1'b0;
            if (filt_clk && (filt_next == '0)) begin
                filt_clk <= 1'b0;
                fall     <= 1'b1;
            end else if (!filt_clk && (&filt_next)) begin
                filt_clk <= 1'b1;
            end
        end
    end

    ps2_state_t      state;
    ps2_state_t      state_nxt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_c;
    logic            frame_err_c;
    logic            parity_err_c;
    logic            byte_good_c;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_bit;
    logic            par_ok;
    assign par_ok = ^{shreg, par_bit};
`endif

    assign timeout_c = (state != IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge FPGAClk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout_c) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_s) state_nxt = DATA;
                DATA:    if (bit_idx == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        frame_err_c  = 1'b0;
        parity_err_c = 1'b0;
        byte_good_c  = 1'b0;
        if (timeout_c) begin
            frame_err_c = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: if (data_s) frame_err_c = 1'b1;
                STOP: begin
                    if (!data_s) frame_err_c = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    else if (!par_ok) parity_err_c = 1'b1;
`endif
                    else byte_good_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bit capture and inter-edge timeout counter.
    always_ff @(posedge FPGAClk) begin
        if (rst) begin
            bit_idx <= '0;
            shreg   <= '0;
            to_cnt  <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= 1'b0;
`endif
        end else begin
            to_cnt <= (fall || state == IDLE) ? '0 : to_cnt + TO_W'(1);
            if (fall) begin
                case (state)
                    IDLE: bit_idx <= '0;
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
`ifdef PS2_PARITY_CHECK_EN
                    PARITY: par_bit <= data_s;
`endif
                    default: ;
                endcase
            end
        end
    end

    logic       ext_pend;
    logic       brk_pend;
    logic       push_q;
    ps2_entry_t push_entry;

    always_ff @(posedge FPGAClk) begin
        if (rst) begin
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            push_q     <= 1'b0;
            push_entry <= '0;
            err_frame  <= 1'b0;
            err_parity <= 1'b0;
        end else begin
            err_frame  <= frame_err_c;
            err_parity <= parity_err_c;
            push_q     <= 1'b0;
            if (byte_good_c) begin
                if (shreg == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (shreg == PS2_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    push_q          <= 1'b1;
                    push_entry.ext  <= ext_pend;
                    push_entry.brk  <= brk_pend;
                    push_entry.code <= shreg;
                    ext_pend        <= 1'b0;
                    brk_pend        <= 1'b0;
                end
            end
        end
    end

    ps2_entry_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    assign key_valid = !fifo_empty;
    assign pop       = key_valid && key_ready;
    assign key_code  = head.code;
    assign key_break = head.brk;
    assign key_ext   = head.ext;

    ps2_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .FPGAClk (FPGAClk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (push_entry),
        .rd_en   (key_ready),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Shift state follows the write attempt, whether or not the FIFO had room.
    logic lsh;
    logic rsh;
    logic lsh_d;
    logic rsh_d;

    always_comb begin
        lsh_d = lsh;
        rsh_d = rsh;
        if (push_q && !push_entry.ext) begin
            if (push_entry.code == PS2_LSHIFT) lsh_d = !push_entry.brk;
            if (push_entry.code == PS2_RSHIFT) rsh_d = !push_entry.brk;
        end
    end

    always_ff @(posedge FPGAClk) begin
        if (rst) begin
            lsh          <= 1'b0;
            rsh          <= 1'b0;
            shift        <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            lsh          <= lsh_d;
            rsh          <= rsh_d;
            shift        <= lsh_d | rsh_d;
            err_overflow <= push_q && fifo_full && !pop;
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: bit-level PS/2 driver, reference model and entry scoreboard.
module tb_ps2_key_rx;

    localparam int unsigned FL    = 8;
    localparam int unsigned TO    = 2000;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned HALF  = 20;
    localparam int unsigned LAT   = FL + 4;

    logic       FPGAClk = 1'b0;
    logic       rst     = 1'b1;
    logic       PS2Clk  = 1'b1;
    logic       datain  = 1'b1;
    logic       key_ready = 1'b0;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic [3:0] fifo_count;
    logic       shift;
    logic       err_parity;
    logic       err_frame;
    logic       err_overflow;

    int errors = 0;
    int checks = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0;
    int exp_par = 0, exp_frm = 0, exp_ovf = 0;
    logic [9:0] exp_q[$];
    logic m_ext = 1'b0, m_brk = 1'b0, m_lsh = 1'b0, m_rsh = 1'b0;

    ps2_key_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .FPGAClk      (FPGAClk),
        .rst          (rst),
        .PS2Clk       (PS2Clk),
        .datain       (datain),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_break    (key_break),
        .key_ext      (key_ext),
        .fifo_count   (fifo_count),
        .shift        (shift),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .err_overflow (err_overflow)
    );

    always #5 FPGAClk = ~FPGAClk;

    // Count high cycles of each error output; a single event should give exactly one.
    always @(negedge FPGAClk) begin
        if (err_parity === 1'b1)   n_par++;
        if (err_frame === 1'b1)    n_frm++;
        if (err_overflow === 1'b1) n_ovf++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge FPGAClk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        datain = v;
        tick(HALF);
        PS2Clk = 1'b0;
        tick(HALF);
        PS2Clk = 1'b1;
    endtask

    // Everything up to and including the falling clock of the stop bit.
    task automatic send_head(input logic [7:0] b, input logic flip);
        logic par;
        par = ~(^b) ^ flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        datain = 1'b1;
        tick(HALF);
        PS2Clk = 1'b0;
    endtask

    task automatic end_frame(input int elapsed);
        tick(HALF - elapsed);
        PS2Clk = 1'b1;
        tick(HALF);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic flip);
        bit good;
`ifdef PS2_PARITY_CHECK_EN
        good = !flip;
`else
        good = 1'b1;
`endif
        if (!good) begin
            exp_par++;
            return;
        end
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
            else exp_ovf++;
            if (!m_ext && b == 8'h12) m_lsh = !m_brk;
            if (!m_ext && b == 8'h59) m_rsh = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic key(input logic [7:0] b, input logic flip);
        model_byte(b, flip);
        send_head(b, flip);
        end_frame(0);
    endtask

    // Pop every expected entry and compare it to the FIFO head.
    task automatic drain(input string tag);
        logic [9:0] exp;
        logic [9:0] got;
        while (exp_q.size() > 0) begin
            int n = 0;
            while (!key_valid && n < 100) begin
                tick(1);
                n++;
            end
            exp = exp_q.pop_front();
            got = {key_ext, key_break, key_code};
            checks++;
            if (key_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL %s_entry: got valid=%b {ext,brk,code}=%h required valid=1 %h",
                         tag, key_valid, got, exp);
            end
            key_ready = 1'b1;
            tick(1);
            key_ready = 1'b0;
        end
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL %s_drained_count: got %0d required 0", tag, fifo_count);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(2);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b required 0", key_valid);
        end
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d required 0", fifo_count);
        end
        checks++;
        if ({key_code, key_break, key_ext} !== 10'd0) begin
            errors++; $display("FAIL reset_head: got %h required 0", {key_code, key_break, key_ext});
        end
        checks++;
        if ({shift, err_parity, err_frame, err_overflow} !== 4'd0) begin
            errors++; $display("FAIL reset_flags: got %b required 0000",
                               {shift, err_parity, err_frame, err_overflow});
        end
    endtask

    task automatic test_basic;
        model_byte(8'h1C, 1'b0);
        send_head(8'h1C, 1'b0);
        tick(LAT - 1);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: got %b required 0", key_valid);
        end
        tick(1);
        checks++;
        if (key_valid !== 1'b1) begin
            errors++; $display("FAIL basic_latency_valid: got %b required 1", key_valid);
        end
        end_frame(LAT);
        checks++;
        if (fifo_count !== 4'd1) begin
            errors++; $display("FAIL basic_count: got %0d required 1", fifo_count);
        end
        drain("basic");
    endtask

    task automatic test_prefix;
        key(8'hF0, 1'b0);
        key(8'h1C, 1'b0);
        key(8'hE0, 1'b0);
        key(8'hF0, 1'b0);
        key(8'h75, 1'b0);
        checks++;
        if (fifo_count !== 4'd2) begin
            errors++; $display("FAIL prefix_count: got %0d required 2", fifo_count);
        end
        drain("prefix");
    endtask

    task automatic test_shift;
        key(8'h12, 1'b0);
        checks++;
        if (shift !== 1'b1) begin
            errors++; $display("FAIL shift_lmake: got %b required 1", shift);
        end
        key(8'hE0, 1'b0);
        key(8'hF0, 1'b0);
        key(8'h12, 1'b0);
        checks++;
        if (shift !== 1'b1) begin
            errors++; $display("FAIL shift_ext_ignored: got %b required 1", shift);
        end
        key(8'h59, 1'b0);
        key(8'hF0, 1'b0);
        key(8'h12, 1'b0);
        checks++;
        if (shift !== 1'b1) begin
            errors++; $display("FAIL shift_rmake_lbreak: got %b required 1", shift);
        end
        key(8'hF0, 1'b0);
        key(8'h59, 1'b0);
        checks++;
        if (shift !== 1'b0) begin
            errors++; $display("FAIL shift_rbreak: got %b required 0", shift);
        end
        drain("shift");
    endtask

    task automatic test_parity;
        key(8'h1C, 1'b1);
        checks++;
        if (n_par !== exp_par) begin
            errors++; $display("FAIL parity_pulses: got %0d required %0d", n_par, exp_par);
        end
        checks++;
        if (fifo_count !== 4'(exp_q.size())) begin
            errors++; $display("FAIL parity_count: got %0d required %0d", fifo_count, exp_q.size());
        end
        drain("parity");
    endtask

    task automatic test_idle_glitch;
        exp_frm++;
        send_bit(1'b1);
        tick(HALF);
        checks++;
        if (n_frm !== exp_frm) begin
            errors++; $display("FAIL idle_frame_err: got %0d required %0d", n_frm, exp_frm);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 9; i++) key(8'(8'h20 + i), 1'b0);
        checks++;
        if (fifo_count !== 4'd8) begin
            errors++; $display("FAIL ovf_count: got %0d required 8", fifo_count);
        end
        checks++;
        if (n_ovf !== exp_ovf || exp_ovf != 1) begin
            errors++; $display("FAIL ovf_pulses: got %0d required 1", n_ovf);
        end
        checks++;
        if (key_code !== 8'h20) begin
            errors++; $display("FAIL ovf_head: got %h required 20", key_code);
        end
        // Pop exactly in the cycle the new entry is written while full.
        void'(exp_q.pop_front());
        model_byte(8'h30, 1'b0);
        send_head(8'h30, 1'b0);
        tick(LAT - 1);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        end_frame(LAT);
        checks++;
        if (fifo_count !== 4'd8) begin
            errors++; $display("FAIL pushpop_count: got %0d required 8", fifo_count);
        end
        checks++;
        if (n_ovf !== exp_ovf) begin
            errors++; $display("FAIL pushpop_ovf: got %0d required %0d", n_ovf, exp_ovf);
        end
        checks++;
        if (key_code !== 8'h21) begin
            errors++; $display("FAIL pushpop_head: got %h required 21", key_code);
        end
        drain("overflow");
    endtask

    task automatic test_timeout;
        int n;
        exp_frm++;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tick(TO - 100);
        checks++;
        if (n_frm !== exp_frm - 1) begin
            errors++; $display("FAIL timeout_early: got %0d required %0d", n_frm, exp_frm - 1);
        end
        n = 0;
        while (n_frm != exp_frm && n < 400) begin
            tick(1);
            n++;
        end
        tick(2);
        checks++;
        if (n_frm !== exp_frm) begin
            errors++; $display("FAIL timeout_frame_err: got %0d required %0d", n_frm, exp_frm);
        end
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++; $display("FAIL timeout_count: got %0d required 0", fifo_count);
        end
        key(8'h1C, 1'b0);
        drain("timeout");
    endtask

    task automatic test_reset_mid;
        key(8'h12, 1'b0);
        key(8'h1C, 1'b0);
        checks++;
        if (shift !== 1'b1 || fifo_count !== 4'd2) begin
            errors++; $display("FAIL rstmid_setup: got shift=%b count=%0d required 1 2", shift, fifo_count);
        end
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        exp_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_lsh = 1'b0; m_rsh = 1'b0;
        checks++;
        if (key_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++; $display("FAIL rstmid_fifo: got valid=%b count=%0d required 0 0", key_valid, fifo_count);
        end
        checks++;
        if ({key_code, key_break, key_ext, shift, err_parity, err_frame, err_overflow} !== 14'd0) begin
            errors++; $display("FAIL rstmid_outputs: got %h required 0",
                               {key_code, key_break, key_ext, shift, err_parity, err_frame, err_overflow});
        end
        tick(TO + 100);
        checks++;
        if (n_frm !== exp_frm || key_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_quiet: got frame_errs=%0d valid=%b required %0d 0",
                               n_frm, key_valid, exp_frm);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_shift();
        test_parity();
        test_idle_glitch();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
